spi_bus_arbiter: RTL

- Shares one SPI master (start/busy interface) among NREQ sensor-reader clients, e.g. a thermocouple reader and other SPI sensors on the same bus.
- Round-robin grant, one transaction at a time.
- Enforces a minimum chip-select idle gap between transactions.
- A watchdog aborts a hung transfer and reports an error to the owning client.

---
 rtl/spi_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Round-robin sharing of one SPI master among NREQ clients, with
//             an enforced chip-select idle gap and a transfer watchdog.
//  Revision : 1.0
// ============================================================================
module spi_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 1023,
    parameter int CBITS      = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      cur_id,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            spi_start,
    input  logic            spi_busy,
    output logic            spi_abort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [CBITS-1:0] C_TIMEOUT = CBITS'(TIMEOUT);
    localparam logic [CBITS-1:0] C_GAP     = CBITS'(GAP_CYCLES);
    localparam logic [3:0]       C_NREQ    = 4'(NREQ);

    state_t            r_state, w_state_nxt;
    logic [CBITS-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]        r_ptr, w_ptr_nxt, w_ptr_succ;
    logic [2:0]        w_sel, w_cur_id_nxt;
    logic [3:0]        w_idx;
    logic [NREQ-1:0]   w_grant_nxt, w_done_nxt;
    logic              w_found, w_hit, w_timeout;
    logic              w_err_nxt, w_start_nxt, w_abort_nxt;

    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc  = (r_cnt == {CBITS{1'b1}}) ? r_cnt : r_cnt + CBITS'(1);
    assign w_timeout  = (w_cnt_inc == C_TIMEOUT);
    assign w_ptr_succ = (cur_id == 3'(NREQ - 1)) ? 3'd0 : cur_id + 3'd1;

    // Search ptr, ptr+1, ... (mod NREQ); walking downward lets the closest hit win.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= C_NREQ) begin
                w_idx = w_idx - C_NREQ;
            end
            w_hit = |(req & (NREQ'(1) << w_idx));
            if (w_hit) begin
                w_found = 1'b1;
                w_sel   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = grant;
        w_cur_id_nxt = cur_id;
        w_done_nxt   = '0;
        w_err_nxt    = 1'b0;
        w_start_nxt  = 1'b0;
        w_abort_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt  = NREQ'(1) << w_sel;
                    w_cur_id_nxt = w_sel;
                    w_start_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START, S_BUSY: begin
                // Watchdog has priority over any busy edge in the same cycle.
                if (w_timeout) begin
                    w_abort_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = grant;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_succ;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_state == S_START && spi_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end else if (r_state == S_BUSY && !spi_busy) begin
                    w_done_nxt  = grant;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_succ;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_GAP: begin
                w_grant_nxt = '0;
                if (w_cnt_inc == C_GAP) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            grant     <= '0;
            cur_id    <= '0;
            done      <= '0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            spi_abort <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            grant     <= w_grant_nxt;
            cur_id    <= w_cur_id_nxt;
            done      <= w_done_nxt;
            err       <= w_err_nxt;
            spi_start <= w_start_nxt;
            spi_abort <= w_abort_nxt;
        end
    end

endmodule
`default_nettype wire
